pcie_rx_ts_detector: RTL and testbench

Per-lane receive-side parser for PCIe Gen1/Gen2 training sequence ordered sets (TS1/TS2). It sits after the 8b/10b decoder and descrambler-bypass on one lane of the rx link. It hunts for COM, collects the 16-symbol ordered set and validates it. It emits the decoded fields plus a count of consecutive identical sets, which the LTSSM consumes. It is the receive counterpart of the lane transmitter that drives tx_p/tx_n.

---
 rtl/pcie_pkg.sv | 32 +++
 rtl/pcie_rx_ts_detector_if.sv | 35 +++
 rtl/pcie_ts_consec_cnt.sv | 62 ++++++
 rtl/pcie_rx_ts_detector.sv | 144 ++++++++++++++
 tb/tb_pcie_rx_ts_detector.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe receive-side training-sequence parser.
//   - Symbol constants (K28.5 COM, K23.7 PAD, K28.0 SKP, TS1/TS2 identifiers)
//   - ts_fields_t : decoded contents of one TS1/TS2 ordered set
//   - ts_fsm_e    : parser state encoding
package pcie_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;  // K28.5
  localparam logic [7:0] PAD_SYM = 8'hF7;  // K23.7
  localparam logic [7:0] SKP_SYM = 8'h1C;  // K28.0
  localparam logic [7:0] TS1_ID  = 8'h4A;  // D10.2
  localparam logic [7:0] TS2_ID  = 8'h45;  // D5.2

  localparam int TS_LEN = 16;  // symbols per training sequence, COM included

  typedef struct packed {
    logic       is_ts2;
    logic [7:0] link_num;
    logic       link_pad;
    logic [7:0] lane_num;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctrl;
  } ts_fields_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } ts_fsm_e;

endpackage

// File: rtl/pcie_rx_ts_detector_if.sv
// Symbol input and decoded-TS output bundle of one receive lane.
//   master : symbol source / LTSSM side (drives sym_*, observes ts_*)
//   slave  : the TS detector (observes sym_*, drives ts_*)
interface pcie_rx_ts_detector_if #(
  parameter int CNT_W = 4
);
  logic             sym_valid;
  logic [7:0]       sym_data;
  logic             sym_is_k;

  logic             ts_valid;
  logic             ts_is_ts2;
  logic [7:0]       ts_link_num;
  logic             ts_link_pad;
  logic [7:0]       ts_lane_num;
  logic             ts_lane_pad;
  logic [7:0]       ts_n_fts;
  logic [7:0]       ts_rate_id;
  logic [7:0]       ts_train_ctrl;
  logic [CNT_W-1:0] ts_consec_cnt;
  logic             ts_err;

  modport master (
    output sym_valid, sym_data, sym_is_k,
    input  ts_valid, ts_is_ts2, ts_link_num, ts_link_pad, ts_lane_num,
           ts_lane_pad, ts_n_fts, ts_rate_id, ts_train_ctrl, ts_consec_cnt, ts_err
  );

  modport slave (
    input  sym_valid, sym_data, sym_is_k,
    output ts_valid, ts_is_ts2, ts_link_num, ts_link_pad, ts_lane_num,
           ts_lane_pad, ts_n_fts, ts_rate_id, ts_train_ctrl, ts_consec_cnt, ts_err
  );

endinterface

// File: rtl/pcie_ts_consec_cnt.sv
// Consecutive-identical training-sequence counter.
//   clk, rst : lane clock, synchronous active-high reset
//   update   : a completed set is presented on 'fields' this cycle
//   clr      : drop the reference set and zero the count
//   fields   : the completed set
//   cnt      : count including the set being presented (while update is high)
module pcie_ts_consec_cnt
  import pcie_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             clr,
  input  ts_fields_t       fields,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ts_fields_t       ref_reg, ref_next;
  logic             ref_valid_reg, ref_valid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    ref_next       = ref_reg;
    ref_valid_next = ref_valid_reg;
    cnt_next       = cnt_reg;
    if (update) begin
      // A clear in the same cycle invalidates the old reference, so this set
      // becomes the new reference and counts as the first.
      ref_next       = fields;
      ref_valid_next = 1'b1;
      if (!clr && ref_valid_reg && (fields == ref_reg)) begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
      end else begin
        cnt_next = CNT_ONE;
      end
    end else if (clr) begin
      cnt_next       = '0;
      ref_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_reg       <= '0;
      ref_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      ref_reg       <= ref_next;
      ref_valid_reg <= ref_valid_next;
      cnt_reg       <= cnt_next;
    end
  end

  // The updated count is shown in the same cycle as ts_valid.
  assign cnt = update ? cnt_next : cnt_reg;

endmodule

// File: rtl/pcie_rx_ts_detector.sv
// Per-lane TS1/TS2 ordered-set parser.
//   clk, rst   : lane symbol clock, synchronous active-high reset
//   consec_clr : zero the consecutive count and forget the reference set
//   bus        : slave side of pcie_rx_ts_detector_if
//                sym_valid/sym_data/sym_is_k in; decoded fields,
//                ts_valid / ts_err pulses and consecutive count out
module pcie_rx_ts_detector #(
  parameter int         CNT_W   = 4,
  parameter logic [7:0] COM_SYM = pcie_pkg::COM_SYM,
  parameter logic [7:0] PAD_SYM = pcie_pkg::PAD_SYM,
  parameter logic [7:0] TS1_ID  = pcie_pkg::TS1_ID,
  parameter logic [7:0] TS2_ID  = pcie_pkg::TS2_ID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  consec_clr,
  pcie_rx_ts_detector_if.slave  bus
);

  import pcie_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(TS_LEN - 1);

  ts_fsm_e          state_reg, state_next;
  logic [3:0]       idx_reg, idx_next;
  ts_fields_t       work_reg, work_next;  // set being collected
  ts_fields_t       out_reg, out_next;    // last complete set (output fields)
  logic             err_reg, err_next;
  logic             is_com;
  logic             sym_ok;
  logic [7:0]       id_exp;
  logic [CNT_W-1:0] cnt;

  assign is_com = bus.sym_is_k && (bus.sym_data == COM_SYM);
  assign id_exp = work_reg.is_ts2 ? TS2_ID : TS1_ID;

  // Legality of the current symbol at the current index of the set.
  always_comb begin
    sym_ok = 1'b0;
    case (idx_reg)
      4'd1, 4'd2:       sym_ok = !bus.sym_is_k || (bus.sym_data == PAD_SYM);
      4'd3, 4'd4, 4'd5: sym_ok = !bus.sym_is_k;
      4'd6:             sym_ok = !bus.sym_is_k &&
                                 ((bus.sym_data == TS1_ID) || (bus.sym_data == TS2_ID));
      default:          sym_ok = !bus.sym_is_k && (bus.sym_data == id_exp);
    endcase
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    work_next  = work_reg;
    out_next   = out_reg;
    err_next   = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (bus.sym_valid) begin
          if (sym_ok) begin
            case (idx_reg)
              4'd1: begin
                work_next.link_num = bus.sym_data;
                work_next.link_pad = bus.sym_is_k;
              end
              4'd2: begin
                work_next.lane_num = bus.sym_data;
                work_next.lane_pad = bus.sym_is_k;
              end
              4'd3: work_next.n_fts      = bus.sym_data;
              4'd4: work_next.rate_id    = bus.sym_data;
              4'd5: work_next.train_ctrl = bus.sym_data;
              4'd6: work_next.is_ts2     = (bus.sym_data == TS2_ID);
              default: ;
            endcase
            if (idx_reg == LAST_IDX) begin
              // Symbols 7..15 carry no fields, so work_reg is already complete.
              state_next = DONE;
              idx_next   = 4'd0;
              out_next   = work_reg;
            end else begin
              idx_next = idx_reg + 4'd1;
            end
          end else begin
            err_next = 1'b1;
            if (is_com) begin
              idx_next = 4'd1;  // the offending COM starts a fresh set
            end else begin
              state_next = HUNT;
              idx_next   = 4'd0;
            end
          end
        end
      end
      default: begin
        // HUNT and DONE share the COM search so back-to-back sets are kept.
        state_next = HUNT;
        idx_next   = 4'd0;
        if (bus.sym_valid && is_com) begin
          state_next = COLLECT;
          idx_next   = 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HUNT;
      idx_reg   <= 4'd0;
      work_reg  <= '0;
      out_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      work_reg  <= work_next;
      out_reg   <= out_next;
      err_reg   <= err_next;
    end
  end

  pcie_ts_consec_cnt #(
    .CNT_W (CNT_W)
  ) u_consec_cnt (
    .clk    (clk),
    .rst    (rst),
    .update (state_reg == DONE),
    .clr    (consec_clr),
    .fields (out_reg),
    .cnt    (cnt)
  );

  assign bus.ts_valid      = (state_reg == DONE);
  assign bus.ts_err        = err_reg;
  assign bus.ts_is_ts2     = out_reg.is_ts2;
  assign bus.ts_link_num   = out_reg.link_num;
  assign bus.ts_link_pad   = out_reg.link_pad;
  assign bus.ts_lane_num   = out_reg.lane_num;
  assign bus.ts_lane_pad   = out_reg.lane_pad;
  assign bus.ts_n_fts      = out_reg.n_fts;
  assign bus.ts_rate_id    = out_reg.rate_id;
  assign bus.ts_train_ctrl = out_reg.train_ctrl;
  assign bus.ts_consec_cnt = cnt;

endmodule

// File: tb/tb_pcie_rx_ts_detector.sv
// Self-checking bench for pcie_rx_ts_detector.
module tb_pcie_rx_ts_detector;
  import pcie_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    ts_fields_t       f;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic consec_clr;

  pcie_rx_ts_detector_if #(.CNT_W(CNT_W)) bus ();

  pcie_rx_ts_detector #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .consec_clr (consec_clr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  rec_t obs_q[$];
  rec_t exp_q[$];
  int   err_pulses = 0;

  // Reference model state: last accepted set and its running count.
  bit         ref_valid = 0;
  ts_fields_t ref_f;
  int         ref_cnt = 0;

  function automatic ts_fields_t cur_fields();
    ts_fields_t f;
    f.is_ts2     = bus.ts_is_ts2;
    f.link_num   = bus.ts_link_num;
    f.link_pad   = bus.ts_link_pad;
    f.lane_num   = bus.ts_lane_num;
    f.lane_pad   = bus.ts_lane_pad;
    f.n_fts      = bus.ts_n_fts;
    f.rate_id    = bus.ts_rate_id;
    f.train_ctrl = bus.ts_train_ctrl;
    return f;
  endfunction

  // Monitor: sample mid-cycle, record every reported set and error pulse.
  always @(negedge clk) begin
    if (bus.ts_valid === 1'b1) obs_q.push_back(rec_t'{f: cur_fields(), cnt: bus.ts_consec_cnt});
    if (bus.ts_err === 1'b1) err_pulses++;
  end

  function automatic void model_done(input ts_fields_t f, input bit clr);
    if (clr || !ref_valid || (f != ref_f)) ref_cnt = 1;
    else ref_cnt = (ref_cnt < CNT_MAX) ? ref_cnt + 1 : CNT_MAX;
    ref_f     = f;
    ref_valid = 1;
    exp_q.push_back(rec_t'{f: f, cnt: CNT_W'(ref_cnt)});
  endfunction

  function automatic void model_clear();
    ref_valid = 0;
    ref_cnt   = 0;
  endfunction

  function automatic ts_fields_t rand_fields(input bit is_ts2);
    ts_fields_t f;
    f.is_ts2     = is_ts2;
    f.link_pad   = ($urandom_range(3) == 0);
    f.link_num   = f.link_pad ? PAD_SYM : 8'($urandom);
    f.lane_pad   = ($urandom_range(3) == 0);
    f.lane_num   = f.lane_pad ? PAD_SYM : 8'($urandom);
    f.n_fts      = 8'($urandom);
    f.rate_id    = 8'($urandom);
    f.train_ctrl = 8'($urandom);
    return f;
  endfunction

  task automatic sym_of(input ts_fields_t f, input int i, output logic [7:0] d, output logic k);
    k = 1'b0;
    case (i)
      0:       begin d = COM_SYM; k = 1'b1; end
      1:       begin d = f.link_num; k = f.link_pad; end
      2:       begin d = f.lane_num; k = f.lane_pad; end
      3:       d = f.n_fts;
      4:       d = f.rate_id;
      5:       d = f.train_ctrl;
      default: d = f.is_ts2 ? TS2_ID : TS1_ID;
    endcase
  endtask

  // Random junk (possibly COM) is shown during gaps with sym_valid low.
  task automatic drive_sym(input logic [7:0] d, input logic k, input int gap_max);
    int gaps;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max)) : 0;
    repeat (gaps) begin
      bus.sym_valid = 1'b0;
      bus.sym_data  = ($urandom_range(1) == 0) ? COM_SYM : 8'($urandom);
      bus.sym_is_k  = 1'($urandom_range(1));
      @(posedge clk); #1;
    end
    bus.sym_valid = 1'b1;
    bus.sym_data  = d;
    bus.sym_is_k  = k;
    @(posedge clk); #1;
    bus.sym_valid = 1'b0;
  endtask

  task automatic send_set(input ts_fields_t f, input int first, input int last, input int gap_max);
    logic [7:0] d;
    logic       k;
    for (int i = first; i <= last; i++) begin
      sym_of(f, i, d, k);
      drive_sym(d, k, gap_max);
    end
  endtask

  task automatic idle(input int n);
    bus.sym_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (bus.ts_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ts_valid); end
    checks++;
    if (bus.ts_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.ts_err); end
    checks++;
    if (cur_fields() !== ts_fields_t'('0)) begin errors++; $display("FAIL reset_fields: got %h want 0", cur_fields()); end
    checks++;
    if (bus.ts_consec_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.ts_consec_cnt); end
    rst = 1'b0;
    model_clear();
    idle(2);
    $display("test_reset done");
  endtask

  task automatic test_ts1_basic();
    ts_fields_t f;
    f = '0;
    f.lane_num = PAD_SYM;
    f.lane_pad = 1'b1;
    f.n_fts    = 8'h1F;
    f.rate_id  = 8'h02;
    send_set(f, 0, 14, 0);
    checks++;
    if (bus.ts_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b want 0", bus.ts_valid); end
    send_set(f, 15, 15, 0);
    model_done(f, 0);
    checks++;
    if (bus.ts_valid !== 1'b1) begin errors++; $display("FAIL t1_latency: got %b want 1", bus.ts_valid); end
    checks++;
    if ({bus.ts_is_ts2, bus.ts_lane_pad, bus.ts_n_fts} !== {1'b0, 1'b1, 8'h1F})
      begin errors++; $display("FAIL t1_fields: got ts2=%b lpad=%b nfts=%h want 0 1 1f", bus.ts_is_ts2, bus.ts_lane_pad, bus.ts_n_fts); end
    checks++;
    if (bus.ts_consec_cnt !== CNT_W'(1)) begin errors++; $display("FAIL t1_cnt: got %0d want 1", bus.ts_consec_cnt); end
    idle(5);
    checks++;
    if (bus.ts_n_fts !== 8'h1F) begin errors++; $display("FAIL t1_hold: got %h want 1f", bus.ts_n_fts); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL t1_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL t1_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_ts1_basic done");
  endtask

  task automatic test_back_to_back();
    ts_fields_t f;
    f = rand_fields(1);
    for (int n = 0; n < 10; n++) begin send_set(f, 0, 15, 0); model_done(f, 0); end
    for (int n = 0; n < 8; n++)  begin send_set(f, 0, 15, 3); model_done(f, 0); end
    idle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_back_to_back done");
  endtask

  task automatic test_bad_id();
    ts_fields_t f;
    int e0;
    f = rand_fields(0);
    send_set(f, 0, 15, 1); model_done(f, 0);
    e0 = err_pulses;
    send_set(f, 0, 8, 1);
    drive_sym(TS2_ID, 1'b0, 1);
    send_set(f, 10, 15, 1);
    idle(3);
    send_set(f, 0, 15, 1); model_done(f, 0);
    idle(4);
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL bad_id_err: got %0d pulses want 1", err_pulses - e0); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bad_id_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL bad_id_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_bad_id done");
  endtask

  task automatic test_com_restart();
    ts_fields_t a, b;
    int e0;
    a = rand_fields(0);
    b = rand_fields(1);
    e0 = err_pulses;
    send_set(a, 0, 7, 2);
    send_set(b, 0, 15, 2); model_done(b, 0);
    idle(4);
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL com_err: got %0d pulses want 1", err_pulses - e0); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL com_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL com_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_com_restart done");
  endtask

  task automatic test_lane_change_clr();
    ts_fields_t f, g;
    consec_clr = 1'b1; @(posedge clk); #1; consec_clr = 1'b0;
    model_clear();
    f = rand_fields(0);
    f.lane_pad = 1'b0;
    f.lane_num = 8'h07;
    g = f;
    g.lane_num = 8'h03;
    for (int n = 0; n < 3; n++) begin send_set(f, 0, 15, 1); model_done(f, 0); end
    // clear coinciding with DONE, first on a differing set, then on an equal one
    send_set(g, 0, 15, 1);
    consec_clr = 1'b1; @(posedge clk); #1; consec_clr = 1'b0;
    model_done(g, 1);
    send_set(g, 0, 15, 1); model_done(g, 0);
    send_set(g, 0, 15, 1);
    consec_clr = 1'b1; @(posedge clk); #1; consec_clr = 1'b0;
    model_done(g, 1);
    idle(2);
    consec_clr = 1'b1; @(posedge clk); #1; consec_clr = 1'b0;
    model_clear();
    checks++;
    if (bus.ts_consec_cnt !== CNT_W'(ref_cnt)) begin errors++; $display("FAIL clr_idle_cnt: got %0d want %0d", bus.ts_consec_cnt, ref_cnt); end
    send_set(g, 0, 15, 1); model_done(g, 0);
    idle(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clr_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL clr_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_lane_change_clr done");
  endtask

  task automatic test_reset_mid();
    ts_fields_t f;
    int e0;
    f = rand_fields(0);
    send_set(f, 0, 15, 0); model_done(f, 0);
    idle(2);
    obs_q.delete(); exp_q.delete();
    e0 = err_pulses;
    send_set(f, 0, 9, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.ts_valid, bus.ts_err} !== 2'b00) begin errors++; $display("FAIL rst_mid_pulses: got %b%b want 00", bus.ts_valid, bus.ts_err); end
    checks++;
    if (cur_fields() !== ts_fields_t'('0)) begin errors++; $display("FAIL rst_mid_fields: got %h want 0", cur_fields()); end
    checks++;
    if (bus.ts_consec_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt: got %0d want 0", bus.ts_consec_cnt); end
    rst = 1'b0;
    model_clear();
    send_set(f, 0, 15, 2); model_done(f, 0);
    idle(4);
    checks++;
    if (err_pulses != e0) begin errors++; $display("FAIL rst_mid_err: got %0d pulses want 0", err_pulses - e0); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_mid_count: got %0d sets want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      rec_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_set: got %h want %h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    $display("test_reset_mid done");
  endtask

  initial begin
    rst           = 1'b1;
    consec_clr    = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 8'h00;
    bus.sym_is_k  = 1'b0;
    test_reset();
    test_ts1_basic();
    test_back_to_back();
    test_bad_id();
    test_com_restart();
    test_lane_change_clr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
